ram_bus_arbiter: RTL and testbench
==================================

Name: ram_bus_arbiter

Overview:
- Shares the single RAM port between four requesters: dcache0, icache0, dcache1, icache1.
- Sits between the two cores' caches and the RAM model, in front of the coherence logic's RAM path.
- Grants one requester at a time, using registered round-robin priority.
- Holds the grant across a data-cache block of BLOCK_WORDS consecutive words, so a block transfer is never interleaved with another requester.

Parameters:
- BLOCK_WORDS, 2, max consecutive words one dcache grant may transfer before re-arbitration
- NREQ, 4, requester count (fixed mapping: 0=dcache0, 1=icache0, 2=dcache1, 3=icache1)

Ports:
- CLK  in  1  system clock
- nRST  in  1  reset; asynchronous, active-low
- iREN  in  2  icache read request, per core
- iaddr  in  2x32  icache word address, per core
- dREN  in  2  dcache read request, per core
- dWEN  in  2  dcache write request, per core
- daddr  in  2x32  dcache word address, per core
- dstore  in  2x32  dcache write data, per core
- ramstate  in  2  RAM status (FREE=0, BUSY=1, ACCESS=2, ERROR=3; cpu_types_pkg encoding)
- ramload  in  32  RAM read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- iwait  out  2  icache wait, per core
- dwait  out  2  dcache wait, per core
- iload  out  2x32  icache read data, per core
- dload  out  2x32  dcache read data, per core
- grant  out  4  one-hot current owner (all zero when idle)

Behaviour:
- Request vector: req[0]=dREN[0]|dWEN[0], req[1]=iREN[0], req[2]=dREN[1]|dWEN[1], req[3]=iREN[1].
- Reset (async, nRST=0), effective immediately, including mid-transfer:
  - state=IDLE, ptr=0, owner=none, wcnt=0
  - grant=0, ramREN=ramWEN=0, ramaddr=0, ramstore=0
  - iwait=2'b11, dwait=2'b11, iload=dload=0
- States: IDLE, XFER.
- IDLE:
  - No RAM enables; all waits 1.
  - If any req: owner <= first requester at or after ptr (cyclic order ptr, ptr+1, ... mod 4); wcnt <= 0; go to XFER.
  - Arbitration latency: exactly 1 cycle from request to RAM enable.
- XFER:
  - Drive RAM from owner only.
  - dcache owner: dWEN has priority over dREN when both high. Write → ramWEN=1, ramstore=dstore, ramaddr=daddr. Read → ramREN=1, ramaddr=daddr.
  - icache owner: ramREN=1, ramaddr=iaddr.
- Completion: a cycle with ramstate==ACCESS completes one word.
  - Owner's wait=0 for that cycle only.
  - Owner's load=ramload in that cycle (combinational).
  - Every non-owner wait stays 1.
- After a completed word:
  - Stay in XFER with wcnt+1 only if owner is a dcache AND wcnt < BLOCK_WORDS-1 AND owner's req is still high.
  - Otherwise go to IDLE with ptr <= (owner+1) mod 4.
  - icache owners always release after one word.
- Owner drops req before ACCESS: abort to IDLE next cycle; ptr <= (owner+1) mod 4; no wait pulse.
- ramstate BUSY or FREE in XFER: hold state, waits 1, enables stay asserted.
- ramstate ERROR: hold XFER with waits 1; no timeout.
- Non-owner requests arriving mid-transfer are ignored until IDLE; they are not queued (req lines are level-held).
- Fairness: a continuously requesting requester is granted within 3 other grants.
- grant = one-hot of owner, registered; 0 in IDLE.
- Reset during XFER abandons the word: no wait pulse, enables drop asynchronously.

Test Plan:
- Single icache0 read, addr 0x40, RAM gives ACCESS on the 3rd XFER cycle with ramload=0xDEADBEEF → grant=4'b0010 one cycle after iREN; iwait[0]=0 for exactly 1 cycle with iload[0]=0xDEADBEEF; back to IDLE; ptr=2.
- All four request continuously, ACCESS every 2nd cycle → grant order dcache0(2 words), icache0, dcache1(2 words), icache1, then dcache0 again; no waits deasserted for non-owners.
- dcache1 with dREN=dWEN=1, daddr=0x100, dstore=0x1234 → ramWEN=1, ramREN=0, ramstore=0x1234, ramaddr=0x100.
- dcache0 drops dREN after word 0 of a 2-word block → release after 1 word; next grant goes to icache0 if it is requesting.
- ramstate=ERROR for 10 cycles mid-transfer, then ACCESS → all waits high for 10 cycles, then a single wait pulse for the owner.
- nRST asserted in the same cycle as ACCESS → no wait pulse; all outputs take reset values immediately; grant=0; next arbitration starts from ptr=0.

Source files
------------

// File: rtl/ram_bus_arbiter_if.sv
// Bus bundle between the two cores' caches, the RAM model and the arbiter.
// The arbiter uses the master view and the caches/RAM side uses the slave view.
interface ram_bus_arbiter_if;
    // cache side
    logic [1:0]        iREN;
    logic [1:0][31:0]  iaddr;
    logic [1:0]        dREN;
    logic [1:0]        dWEN;
    logic [1:0][31:0]  daddr;
    logic [1:0][31:0]  dstore;
    logic [1:0]        iwait;
    logic [1:0]        dwait;
    logic [1:0][31:0]  iload;
    logic [1:0][31:0]  dload;
    // RAM side
    logic [1:0]        ramstate;
    logic [31:0]       ramload;
    logic              ramREN;
    logic              ramWEN;
    logic [31:0]       ramaddr;
    logic [31:0]       ramstore;
    // current owner, one-hot
    logic [3:0]        grant;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload, grant
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload, grant
    );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter sharing one RAM port between dcache0, icache0, dcache1
// and icache1. A dcache owner keeps the port for up to BLOCK_WORDS words so
// a block is never interleaved with another requester.

// Per-core wait/load return path: only the current owner sees its word
// complete, everybody else keeps waiting.
module ram_bus_arbiter_port (
    input  logic        own_d,
    input  logic        own_i,
    input  logic        access,
    input  logic [31:0] ramload,
    output logic        dwait,
    output logic        iwait,
    output logic [31:0] dload,
    output logic [31:0] iload
);
    logic d_done, i_done;

    assign d_done = own_d & access;
    assign i_done = own_i & access;
    assign dwait  = ~d_done;
    assign iwait  = ~i_done;
    assign dload  = d_done ? ramload : 32'h0;
    assign iload  = i_done ? ramload : 32'h0;
endmodule

module ram_bus_arbiter #(
    parameter int BLOCK_WORDS = 2,
    parameter int NREQ        = 4
) (
    input logic             CLK,
    input logic             nRST,
    ram_bus_arbiter_if.master bus
);
    localparam int IW = $clog2(NREQ);
    localparam int WW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [WW-1:0] LAST_W = WW'(BLOCK_WORDS - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   owner, owner_n;   // index: bit0 = icache, bit1 = core
    logic [IW-1:0]   ptr, ptr_n;       // highest-priority requester next round
    logic [IW-1:0]   pick;
    logic [IW-1:0]   owner_inc;
    logic [WW-1:0]   wcnt, wcnt_n;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant_q, grant_n;
    logic            owner_req;
    logic            access;
    logic            last_word;
    logic            oc;
    logic [1:0]      dwait_c, iwait_c;
    logic [1:0][31:0] dload_c, iload_c;

    // Requester order is fixed: dcache0, icache0, dcache1, icache1.
    assign req = {bus.iREN[1], bus.dREN[1] | bus.dWEN[1],
                  bus.iREN[0], bus.dREN[0] | bus.dWEN[0]};

    assign oc        = owner[1];
    assign owner_req = req[owner];
    assign owner_inc = owner + IW'(1);
    // A word completes only while the owner still asks for it; a dropped
    // request is treated as an abort even if RAM reports ACCESS.
    assign access    = (state == XFER) && (bus.ramstate == RS_ACCESS) && owner_req;
    // icache owners always release after one word.
    assign last_word = owner[0] || (wcnt >= LAST_W);

    // Round-robin pick: first requester at or after ptr, scanning cyclically.
    always_comb begin
        logic [IW-1:0] idx;
        pick = '0;
        idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + IW'(k);
            if (req[idx]) pick = idx;
        end
    end

    // Arbitration state register; reset abandons any word in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= '0;
            wcnt    <= '0;
            grant_q <= '0;
        end else begin
            state   <= state_n;
            owner   <= owner_n;
            ptr     <= ptr_n;
            wcnt    <= wcnt_n;
            grant_q <= grant_n;
        end
    end

    // Next-state: grant in IDLE, then hold until the block ends or is aborted.
    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        wcnt_n  = wcnt;
        grant_n = grant_q;
        case (state)
            IDLE: begin
                grant_n = '0;
                if (|req) begin
                    owner_n = pick;
                    wcnt_n  = '0;
                    grant_n = NREQ'(1) << pick;
                    state_n = XFER;
                end
            end
            XFER: begin
                if (!owner_req) begin
                    state_n = IDLE;
                    ptr_n   = owner_inc;
                    grant_n = '0;
                end else if (access) begin
                    if (last_word) begin
                        state_n = IDLE;
                        ptr_n   = owner_inc;
                        grant_n = '0;
                    end else begin
                        wcnt_n  = wcnt + WW'(1);
                    end
                end
                // BUSY, FREE and ERROR all just hold the transfer.
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    // RAM request mux: only the owner drives the port; dcache write beats read.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'h0;
        bus.ramstore = 32'h0;
        if (state == XFER) begin
            if (!owner[0]) begin
                if (bus.dWEN[oc]) begin
                    bus.ramWEN   = 1'b1;
                    bus.ramaddr  = bus.daddr[oc];
                    bus.ramstore = bus.dstore[oc];
                end else if (bus.dREN[oc]) begin
                    bus.ramREN   = 1'b1;
                    bus.ramaddr  = bus.daddr[oc];
                end
            end else if (bus.iREN[oc]) begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr[oc];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_core
            logic own_d, own_i;
            assign own_d = (state == XFER) && (owner == IW'(2 * g));
            assign own_i = (state == XFER) && (owner == IW'(2 * g + 1));
            ram_bus_arbiter_port u_port (
                .own_d   (own_d),
                .own_i   (own_i),
                .access  (access),
                .ramload (bus.ramload),
                .dwait   (dwait_c[g]),
                .iwait   (iwait_c[g]),
                .dload   (dload_c[g]),
                .iload   (iload_c[g])
            );
        end
    endgenerate

    assign bus.dwait = dwait_c;
    assign bus.iwait = iwait_c;
    assign bus.dload = dload_c;
    assign bus.iload = iload_c;
    assign bus.grant = grant_q;
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter: reset values, single icache read,
// write priority, round-robin order, early release, ERROR hold, reset abort.
module tb_ram_bus_arbiter;
    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   tests = 0;
    int   fails = 0;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    ram_bus_arbiter_if bus();

    ram_bus_arbiter #(.BLOCK_WORDS(2), .NREQ(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.master)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [3:0] eg [0:14];
    logic [1:0] ed [0:14];
    logic [1:0] ei [0:14];

    initial begin
        bus.iREN = '0; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.daddr = '0; bus.dstore = '0; bus.ramstate = FREE; bus.ramload = '0;

        // reset values
        #2;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_ramREN", 32'(bus.ramREN), 32'h0);
        chk("rst_ramWEN", 32'(bus.ramWEN), 32'h0);
        chk("rst_ramaddr", bus.ramaddr, 32'h0);
        chk("rst_ramstore", bus.ramstore, 32'h0);
        chk("rst_iwait", 32'(bus.iwait), 32'h3);
        chk("rst_dwait", 32'(bus.dwait), 32'h3);
        chk("rst_iload0", bus.iload[0], 32'h0);
        chk("rst_dload1", bus.dload[1], 32'h0);
        #5 nRST = 1'b1;
        tick();

        // single icache0 read, ACCESS on 3rd XFER cycle
        bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h40; bus.ramstate = BUSY;
        #1;
        chk("t1_idle_grant", 32'(bus.grant), 32'h0);
        chk("t1_idle_ren", 32'(bus.ramREN), 32'h0);
        tick();
        chk("t1_grant", 32'(bus.grant), 32'h2);
        chk("t1_ren", 32'(bus.ramREN), 32'h1);
        chk("t1_addr", bus.ramaddr, 32'h40);
        chk("t1_iwait_c1", 32'(bus.iwait), 32'h3);
        tick();
        chk("t1_iwait_c2", 32'(bus.iwait), 32'h3);
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
        #1;
        chk("t1_iwait_pulse", 32'(bus.iwait), 32'h2);
        chk("t1_iload", bus.iload[0], 32'hDEADBEEF);
        chk("t1_dwait", 32'(bus.dwait), 32'h3);
        tick();
        bus.iREN[0] = 1'b0; bus.ramstate = FREE;
        // both dcaches request now: ptr=2 must pick dcache1
        bus.dREN = 2'b11; bus.daddr[0] = 32'h300; bus.daddr[1] = 32'h100;
        #1;
        chk("t1_back_idle", 32'(bus.grant), 32'h0);
        chk("t1_iwait_after", 32'(bus.iwait), 32'h3);
        chk("t1_iload_after", bus.iload[0], 32'h0);
        tick();
        chk("t1_ptr2_grant", 32'(bus.grant), 32'h4);
        chk("t1_ptr2_addr", bus.ramaddr, 32'h100);

        // dcache1 read+write: write wins
        bus.dWEN[1] = 1'b1; bus.dstore[1] = 32'h1234; bus.ramstate = BUSY;
        #1;
        chk("t3_wen", 32'(bus.ramWEN), 32'h1);
        chk("t3_ren", 32'(bus.ramREN), 32'h0);
        chk("t3_store", bus.ramstore, 32'h1234);
        chk("t3_addr", bus.ramaddr, 32'h100);
        bus.dREN = '0; bus.dWEN = '0;
        #1;
        chk("t3_drop_wen", 32'(bus.ramWEN), 32'h0);
        tick();
        chk("t3_abort_idle", 32'(bus.grant), 32'h0);

        // round robin with all four requesting, ACCESS every 2nd cycle
        nRST = 1'b0; #2; nRST = 1'b1;
        tick();
        eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h0,
               4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        ed = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11,
               2'b01, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b10};
        ei = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11,
               2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11};
        bus.dREN = 2'b11; bus.iREN = 2'b11;
        for (int i = 0; i < 15; i++) begin
            bus.ramstate = (i % 2 == 0) ? ACCESS : BUSY;
            #1;
            chk($sformatf("rr_grant_c%0d", i), 32'(bus.grant), 32'(eg[i]));
            chk($sformatf("rr_dwait_c%0d", i), 32'(bus.dwait), 32'(ed[i]));
            chk($sformatf("rr_iwait_c%0d", i), 32'(bus.iwait), 32'(ei[i]));
            tick();
        end
        bus.dREN = '0; bus.iREN = '0; bus.ramstate = FREE;
        tick();
        chk("rr_end_idle", 32'(bus.grant), 32'h0);

        // dcache0 drops after word 0; icache0 next
        nRST = 1'b0; #2; nRST = 1'b1;
        tick();
        bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h200; bus.iREN[0] = 1'b1;
        bus.iaddr[0] = 32'h80; bus.ramstate = BUSY;
        #1;
        chk("t4_idle", 32'(bus.grant), 32'h0);
        tick();
        chk("t4_grant_d0", 32'(bus.grant), 32'h1);
        chk("t4_addr", bus.ramaddr, 32'h200);
        bus.ramstate = ACCESS; bus.ramload = 32'h55;
        #1;
        chk("t4_dwait_pulse", 32'(bus.dwait), 32'h2);
        chk("t4_dload", bus.dload[0], 32'h55);
        tick();
        bus.dREN[0] = 1'b0; bus.ramstate = BUSY;
        #1;
        chk("t4_drop_dwait", 32'(bus.dwait), 32'h3);
        chk("t4_drop_ren", 32'(bus.ramREN), 32'h0);
        tick();
        chk("t4_release", 32'(bus.grant), 32'h0);
        tick();
        chk("t4_grant_i0", 32'(bus.grant), 32'h2);
        chk("t4_iaddr", bus.ramaddr, 32'h80);

        // ERROR for 10 cycles holds, then one pulse
        bus.ramstate = ERROR;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("t5_err_iwait_%0d", i), 32'(bus.iwait), 32'h3);
            chk($sformatf("t5_err_ren_%0d", i), 32'(bus.ramREN), 32'h1);
            tick();
        end
        bus.ramstate = ACCESS; bus.ramload = 32'hCAFE0001;
        #1;
        chk("t5_pulse", 32'(bus.iwait), 32'h2);
        chk("t5_dwait", 32'(bus.dwait), 32'h3);
        chk("t5_iload", bus.iload[0], 32'hCAFE0001);
        tick();
        bus.iREN[0] = 1'b0; bus.ramstate = FREE;
        bus.iREN[1] = 1'b1; bus.iaddr[1] = 32'h500;
        #1;
        chk("t5_idle", 32'(bus.grant), 32'h0);
        tick();
        chk("t6_grant_i1", 32'(bus.grant), 32'h8);

        // reset in the same cycle as ACCESS
        bus.ramstate = ACCESS; bus.ramload = 32'hAAAA5555; nRST = 1'b0;
        #1;
        chk("t6_iwait", 32'(bus.iwait), 32'h3);
        chk("t6_grant", 32'(bus.grant), 32'h0);
        chk("t6_ren", 32'(bus.ramREN), 32'h0);
        chk("t6_addr", bus.ramaddr, 32'h0);
        chk("t6_iload", bus.iload[1], 32'h0);
        #1;
        nRST = 1'b1; bus.ramstate = BUSY;
        bus.dREN[0] = 1'b1; bus.iREN[0] = 1'b1;
        tick();
        chk("t6_ptr0", 32'(bus.grant), 32'h1);
        bus.dREN = '0; bus.iREN = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
